cordic_sched: RTL and testbench

CORDIC_SCHED -- requirements
Module: cordic_sched

---
 rtl/cordic_sched.sv | 155 +++++++++++++++
 tb/tb_cordic_sched.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sched.sv
// Issue scheduler for a hyperbolic CORDIC pipeline: arbitrates two requesters,
// tracks each operation through the pipeline with a tag and forms the result.
module cordic_sched #(
    parameter int          LAT = 16,
    parameter logic [31:0] X0  = 32'h0001351E
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [31:0] req0_z,
    input  logic [31:0] req1_z,
    input  logic [1:0]  req0_mode,
    input  logic [1:0]  req1_mode,
    input  logic        halt,
    output logic [31:0] cx,
    output logic [31:0] cy,
    output logic [31:0] cz,
    input  logic [31:0] px,
    input  logic [31:0] py,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic        res_id,
    output logic [1:0]  res_mode,
    output logic        idle,
    output logic [4:0]  inflight
);

    typedef enum logic [1:0] {RUN, DRAIN, IDLE} state_t;

    typedef struct packed {
        logic       valid;
        logic       id;
        logic [1:0] mode;
    } tag_t;

    state_t               state, state_next;
    logic                 last_grant;
    logic                 issue;
    logic                 grant_id;
    tag_t                 issue_tag;
    tag_t [LAT-1:0]       tag_sr;
    tag_t                 out_tag;
    logic [31:0]          result;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= RUN;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (halt) state_next = DRAIN;
            DRAIN:   if (!halt) state_next = RUN;
                     else if (inflight == 5'd0) state_next = IDLE;
            IDLE:    if (!halt) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        idle       = (state == IDLE);
        if (state == RUN) begin
            if (req0_valid && req1_valid) begin
                req0_ready = last_grant;
                req1_ready = !last_grant;
            end else begin
                req0_ready = req0_valid;
                req1_ready = req1_valid;
            end
        end
    end

    assign issue    = req0_ready || req1_ready;
    assign grant_id = req1_ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cx         <= '0;
            cy         <= '0;
            cz         <= '0;
            issue_tag  <= '0;
            last_grant <= 1'b1;
        end else if (issue) begin
            cx         <= X0;
            cy         <= '0;
            cz         <= grant_id ? req1_z : req0_z;
            issue_tag  <= '{valid: 1'b1, id: grant_id, mode: (grant_id ? req1_mode : req0_mode)};
            last_grant <= grant_id;
        end else begin
            cx        <= '0;
            cy        <= '0;
            cz        <= '0;
            issue_tag <= '0;
        end
    end

    // The tag enters stage 0 on the same edge the pipeline latches cx/cy/cz,
    // so the last entry lines up with px/py.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tag_sr <= '0;
        end else begin
            tag_sr[0] <= issue_tag;
            for (int i = 1; i < LAT; i++) tag_sr[i] <= tag_sr[i-1];
        end
    end

    assign out_tag = tag_sr[LAT-1];

    always_comb begin
        case (out_tag.mode)
            2'd1:    result = py;
            2'd2:    result = px;
            2'd3:    result = px + py;
            default: result = '0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= 1'b0;
            res_mode  <= '0;
        end else begin
            res_valid <= out_tag.valid;
            if (out_tag.valid) begin
                res_data <= result;
                res_id   <= out_tag.id;
                res_mode <= out_tag.mode;
            end
        end
    end

    // An operation stops counting on the edge that raises its res_valid.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            inflight <= '0;
        end else begin
            case ({issue, out_tag.valid})
                2'b10:   inflight <= inflight + 5'd1;
                2'b01:   inflight <= inflight - 5'd1;
                default: inflight <= inflight;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_sched.sv
// Randomized scoreboard bench for cordic_sched, with a behavioural stand-in
// for the hyperbolic CORDIC pipeline built from real-valued sinh/cosh.
module tb_cordic_sched;

    localparam int          LAT = 16;
    localparam logic [31:0] X0  = 32'h0001351E;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_z = '0, req1_z = '0;
    logic [1:0]  req0_mode = '0, req1_mode = '0;
    logic        halt = 1'b0;
    logic [31:0] cx, cy, cz, px, py;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_id;
    logic [1:0]  res_mode;
    logic        idle;
    logic [4:0]  inflight;

    cordic_sched #(.LAT(LAT), .X0(X0)) dut (
        .CLK(CLK), .RST(RST),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_z(req0_z), .req1_z(req1_z),
        .req0_mode(req0_mode), .req1_mode(req1_mode),
        .halt(halt),
        .cx(cx), .cy(cy), .cz(cz),
        .px(px), .py(py),
        .res_valid(res_valid), .res_data(res_data),
        .res_id(res_id), .res_mode(res_mode),
        .idle(idle), .inflight(inflight)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] data;
        logic        id;
        logic [1:0]  mode;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   pushed   = 0;
    int   popped   = 0;
    int   spurious = 0;
    bit   grant_open = 1'b1;
    bit   last_g     = 1'b1;

    function automatic logic [31:0] fx(input real r);
        return 32'($rtoi($floor(r * 65536.0 + 0.5)));
    endfunction

    function automatic logic [31:0] rsinh(input logic signed [31:0] z);
        return fx($sinh(real'(z) / 65536.0));
    endfunction

    function automatic logic [31:0] rcosh(input logic signed [31:0] z);
        return fx($cosh(real'(z) / 65536.0));
    endfunction

    function automatic logic [31:0] ref_result(input logic [31:0] z, input logic [1:0] m);
        case (m)
            2'd1:    return rsinh(z);
            2'd2:    return rcosh(z);
            2'd3:    return rcosh(z) + rsinh(z);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] rand_z();
        int r;
        r = int'($urandom_range(0, 262143)) - 131072;
        return r;
    endfunction

    function automatic logic [1:0] rand_m();
        return 2'($urandom_range(0, 3));
    endfunction

    // Pipeline stand-in: a seeded stage-1 input comes out LAT edges later as
    // (cosh z, sinh z); bubbles come out as zeros.
    logic [31:0] pipe_x [LAT];
    logic [31:0] pipe_y [LAT];
    always @(posedge CLK) begin
        pipe_x[0] <= (cx != 0) ? rcosh(cz) : 32'd0;
        pipe_y[0] <= (cx != 0) ? rsinh(cz) : 32'd0;
        for (int i = 1; i < LAT; i++) begin
            pipe_x[i] <= pipe_x[i-1];
            pipe_y[i] <= pipe_y[i-1];
        end
    end
    assign px = pipe_x[LAT-1];
    assign py = pipe_y[LAT-1];

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s got 0x%0h want 0x%0h", name, act, exp);
    endtask

    task automatic check_tol(input string name, input int act, input int exp, input int tol);
        n_checks++;
        if (act - exp <= tol && exp - act <= tol) n_pass++;
        else $display("[TB] FAIL %s got 0x%0h want 0x%0h +/- %0d", name, act, exp, tol);
    endtask

    // Monitor: every presented result is matched against the oldest expected one.
    logic [34:0] last_res;
    bit          have_last = 1'b0;
    always @(negedge CLK) begin
        exp_t e;
        if (RST) begin
            have_last = 1'b0;
        end else if (res_valid) begin
            if (q.size() == 0) begin
                spurious++;
                n_checks++;
                $display("[TB] FAIL spurious_res_valid got res_valid=1 want 0 (nothing outstanding)");
            end else begin
                e = q.pop_front();
                popped++;
                check("res_data", 36'(res_data), 36'(e.data));
                check("res_id",   36'(res_id),   36'(e.id));
                check("res_mode", 36'(res_mode), 36'(e.mode));
            end
            last_res  = {res_data, res_id, res_mode};
            have_last = 1'b1;
        end else if (have_last) begin
            check("res_hold", 36'({res_data, res_id, res_mode}), 36'(last_res));
        end
    end

    // One clock of stimulus; readys and inflight are predicted from the
    // arbitration rule and the outstanding count, and grants are scored.
    task automatic applyStimulus(input bit v0, input logic [31:0] z0, input logic [1:0] m0,
                                 input bit v1, input logic [31:0] z1, input logic [1:0] m1,
                                 input bit h);
        bit   e0, e1;
        exp_t item;
        @(posedge CLK);
        #1;
        req0_valid = v0; req0_z = z0; req0_mode = m0;
        req1_valid = v1; req1_z = z1; req1_mode = m1;
        halt = h;
        @(negedge CLK);
        #1;
        e0 = grant_open && v0 && (!v1 || last_g);
        e1 = grant_open && v1 && (!v0 || !last_g);
        check("req0_ready", 36'(req0_ready), 36'(e0));
        check("req1_ready", 36'(req1_ready), 36'(e1));
        check("inflight", 36'(inflight), 36'(pushed - popped));
        if (e0 || e1) begin
            item.data = e1 ? ref_result(z1, m1) : ref_result(z0, m0);
            item.id   = e1;
            item.mode = e1 ? m1 : m0;
            q.push_back(item);
            pushed++;
            last_g = e1;
        end
    endtask

    task automatic idle_cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Single operation, then wait for its result and check issue registers and latency.
    task automatic checkOutput(input bit id, input logic [31:0] z, input logic [1:0] m,
                               output logic [31:0] data);
        int lat;
        if (id) applyStimulus(0, 0, 0, 1, z, m, 0);
        else    applyStimulus(1, z, m, 0, 0, 0, 0);
        lat  = 0;
        data = '0;
        for (int i = 1; i <= 40; i++) begin
            idle_cycle();
            if (i == 1) check("issue_regs", 36'({cx, cz}) , 36'({X0, z}));
            if (i == 1) check("issue_cy", 36'(cy), 36'd0);
            if (i == 2) check("bubble_regs", 36'(cx | cy | cz), 36'd0);
            if (res_valid) begin
                lat  = i;
                data = res_data;
                break;
            end
        end
        check("latency", 36'(lat), 36'(LAT + 2));
    endtask

    initial begin
        logic [31:0] d, s, c, e;
        bit          prev_zero;

        repeat (2) @(negedge CLK);
        check("rst_regs", 36'(cx | cy | cz), 36'd0);
        check("rst_res", 36'({res_valid, res_data, res_id, res_mode}), 36'd0);
        check("rst_status", 36'({idle, inflight}), 36'd0);
        #1 RST = 1'b0;

        // Both requesters valid for six cycles: grants alternate starting with 0.
        for (int i = 0; i < 6; i++)
            applyStimulus(1, rand_z(), rand_m(), 1, rand_z(), rand_m(), 0);
        idle_cycle();
        check("inflight_peak", 36'(inflight), 36'd6);
        repeat (LAT + 4) idle_cycle();

        checkOutput(0, 32'd0, 2'd2, d);
        check_tol("cosh_0", int'(d), 32'h00010000, 16);
        checkOutput(0, 32'h00008000, 2'd1, s);
        checkOutput(1, 32'h00008000, 2'd2, c);
        checkOutput(0, 32'h00008000, 2'd3, e);
        check_tol("sinh_0p5", int'(s), 34151, 32);
        check_tol("cosh_0p5", int'(c), 73901, 32);
        check_tol("exp_0p5", int'(e), 32'h0001A613, 32);
        check_tol("exp_sum", int'(e), int'(s + c), 1);
        checkOutput(1, rand_z(), 2'd0, d);
        check("null_data", 36'(d), 36'd0);
        check("null_inflight", 36'(inflight), 36'd0);

        // Random traffic.
        for (int i = 0; i < 300; i++)
            applyStimulus($urandom_range(0, 99) < 70, rand_z(), rand_m(),
                          $urandom_range(0, 99) < 70, rand_z(), rand_m(), 0);
        repeat (LAT + 4) idle_cycle();

        // Halt with five operations in flight, drain, go idle, resume.
        for (int i = 0; i < 5; i++) applyStimulus(1, rand_z(), rand_m(), 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        check("halt_inflight", 36'(inflight), 36'd5);
        prev_zero  = (pushed == popped);
        grant_open = 1'b0;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1, rand_z(), rand_m(), 1, rand_z(), rand_m(), 1);
            check("drain_idle", 36'(idle), 36'(prev_zero));
            prev_zero = (pushed == popped);
        end
        check("drained", 36'(pushed - popped), 36'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        check("idle_before_resume", 36'(idle), 36'd1);
        grant_open = 1'b1;
        applyStimulus(0, 0, 0, 1, rand_z(), rand_m(), 0);
        check("idle_after_resume", 36'(idle), 36'd0);
        repeat (LAT + 4) idle_cycle();

        // Reset mid-stream with ten in flight.
        for (int i = 0; i < 10; i++)
            applyStimulus(1, rand_z(), rand_m(), 1, rand_z(), rand_m(), 0);
        @(posedge CLK);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        check("pre_rst_inflight", 36'(inflight), 36'd10);
        #1 RST = 1'b1;
        #1;
        check("mid_rst_regs", 36'(cx | cy | cz), 36'd0);
        check("mid_rst_res", 36'({res_valid, res_data, res_id, res_mode}), 36'd0);
        check("mid_rst_status", 36'({idle, inflight}), 36'd0);
        q.delete();
        pushed = 0; popped = 0; last_g = 1'b1;
        @(negedge CLK);
        req0_valid = 1'b1; req0_z = 32'h00004000; req0_mode = 2'd3;
        #1 RST = 1'b0;
        #1;
        check("first_edge_ready", 36'({req0_ready, req1_ready}), 36'b10);
        begin
            exp_t item;
            item.data = ref_result(32'h00004000, 2'd3);
            item.id   = 1'b0;
            item.mode = 2'd3;
            q.push_back(item);
            pushed++;
            last_g = 1'b0;
        end
        repeat (LAT + 6) idle_cycle();
        check("post_rst_delivered", 36'(popped), 36'd1);
        check("no_spurious", 36'(spurious), 36'd0);

        // Bounded final drain.
        for (int i = 0; i < 100 && q.size() != 0; i++) idle_cycle();
        check("final_outstanding", 36'(q.size()), 36'd0);
        check("final_inflight", 36'(inflight), 36'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
